// File: rtl/interrupt_sequencer_if.sv
// rtl/interrupt_sequencer_if.sv - signal bundle between the CPU-side logic and the interrupt sequencer
// Purpose: groups the request, mask, INTA, EOI and response signals of the sequencer.
// Ports (slave = sequencer side):
//   inputs : interrupt_request[7:0], interrupt_mask[7:0], vector_base[4:0], auto_eoi,
//            inta_strobe, eoi_nonspecific, eoi_specific, eoi_level[2:0]
//   outputs: int_out, in_service[7:0], clear_irr[7:0], vector[7:0], vector_valid
interface interrupt_sequencer_if;
    logic [7:0] interrupt_request;
    logic [7:0] interrupt_mask;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       inta_strobe;
    logic       eoi_nonspecific;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] in_service;
    logic [7:0] clear_irr;
    logic [7:0] vector;
    logic       vector_valid;

    modport slave (
        input  interrupt_request, interrupt_mask, vector_base, auto_eoi,
               inta_strobe, eoi_nonspecific, eoi_specific, eoi_level,
        output int_out, in_service, clear_irr, vector, vector_valid
    );

    modport master (
        output interrupt_request, interrupt_mask, vector_base, auto_eoi,
               inta_strobe, eoi_nonspecific, eoi_specific, eoi_level,
        input  int_out, in_service, clear_irr, vector, vector_valid
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - fixed-priority 8-level interrupt sequencer with two-INTA vector delivery
// Purpose: picks the highest-priority unmasked request above the current in-service level,
//          raises int_out, grants on the first INTA, delivers the vector on the second INTA,
//          and retires in-service bits via EOI commands or auto-EOI.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : interrupt_sequencer_if.slave (requests, mask, INTA/EOI strobes, int_out, ISR, clear_irr, vector)
module interrupt_sequencer (
    input  logic                  clock,
    input  logic                  reset,
    interrupt_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_INTA1 = 2'd1,
        WAIT_INTA2 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_int_out;
    logic [7:0] r_isr;
    logic [7:0] r_clear_irr;
    logic [7:0] r_vector;
    logic       r_vector_valid;
    logic [2:0] r_level;
    logic       r_spurious;

    logic       w_int_out_nxt;
    logic [7:0] w_clear_irr_nxt;
    logic [7:0] w_vector_nxt;
    logic       w_vector_valid_nxt;
    logic [2:0] w_level_nxt;
    logic       w_spurious_nxt;
    logic [7:0] w_isr_set;
    logic [7:0] w_auto_clr;
    logic [7:0] w_eoi_clr;
    logic [7:0] w_isr_lowest;
    logic [7:0] w_pending;
    logic [7:0] w_cand_onehot;
    logic       w_cand_valid;
    logic       w_blocked;
    logic [2:0] w_cand_level;

    assign w_pending     = bus.interrupt_request & ~bus.interrupt_mask;
    assign w_cand_onehot = 8'b1 << w_cand_level;
    // Two's-complement trick isolates the lowest set ISR bit for non-specific EOI.
    assign w_isr_lowest  = r_isr & (~r_isr + 8'd1);

    // Scan from IR0 upward; the first in-service bit met blocks every lower-priority level.
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand_level = 3'd0;
        w_blocked    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!w_cand_valid && !w_blocked) begin
                if (r_isr[i]) begin
                    w_blocked = 1'b1;
                end else if (w_pending[i]) begin
                    w_cand_valid = 1'b1;
                    w_cand_level = 3'(i);
                end
            end
        end
    end

    // Specific EOI overrides non-specific when both arrive together.
    always_comb begin
        w_eoi_clr = 8'd0;
        if (bus.eoi_specific) begin
            w_eoi_clr = 8'b1 << bus.eoi_level;
        end else if (bus.eoi_nonspecific) begin
            w_eoi_clr = w_isr_lowest;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_int_out_nxt      = r_int_out;
        w_clear_irr_nxt    = 8'd0;
        w_vector_nxt       = r_vector;
        w_vector_valid_nxt = 1'b0;
        w_level_nxt        = r_level;
        w_spurious_nxt     = r_spurious;
        w_isr_set          = 8'd0;
        w_auto_clr         = 8'd0;
        case (r_state)
            IDLE: begin
                if (w_cand_valid) begin
                    w_state_nxt   = WAIT_INTA1;
                    w_int_out_nxt = 1'b1;
                end
            end
            WAIT_INTA1: begin
                if (bus.inta_strobe) begin
                    w_state_nxt   = WAIT_INTA2;
                    w_int_out_nxt = 1'b0;
                    if (w_cand_valid) begin
                        w_level_nxt     = w_cand_level;
                        w_spurious_nxt  = 1'b0;
                        w_isr_set       = w_cand_onehot;
                        w_clear_irr_nxt = w_cand_onehot;
                    end else begin
                        // Request vanished before INTA: hand out the IR7 vector without touching ISR.
                        w_level_nxt    = 3'd7;
                        w_spurious_nxt = 1'b1;
                    end
                end
            end
            WAIT_INTA2: begin
                if (bus.inta_strobe) begin
                    w_state_nxt        = IDLE;
                    w_vector_nxt       = {bus.vector_base, r_level};
                    w_vector_valid_nxt = 1'b1;
                    if (bus.auto_eoi && !r_spurious) begin
                        w_auto_clr = 8'b1 << r_level;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_int_out_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_int_out      <= 1'b0;
            r_isr          <= 8'd0;
            r_clear_irr    <= 8'd0;
            r_vector       <= 8'd0;
            r_vector_valid <= 1'b0;
            r_level        <= 3'd0;
            r_spurious     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_int_out      <= w_int_out_nxt;
            // Clears act on the pre-update ISR; a grant on the same bit still sets it.
            r_isr          <= (r_isr & ~(w_eoi_clr | w_auto_clr)) | w_isr_set;
            r_clear_irr    <= w_clear_irr_nxt;
            r_vector       <= w_vector_nxt;
            r_vector_valid <= w_vector_valid_nxt;
            r_level        <= w_level_nxt;
            r_spurious     <= w_spurious_nxt;
        end
    end

    assign bus.int_out      = r_int_out;
    assign bus.in_service   = r_isr;
    assign bus.clear_irr    = r_clear_irr;
    assign bus.vector       = r_vector;
    assign bus.vector_valid = r_vector_valid;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - scoreboard bench for interrupt_sequencer with a cycle-level reference model
module tb_interrupt_sequencer;
    logic clock = 1'b0;
    logic reset;

    interrupt_sequencer_if sif();

    interrupt_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    bit [7:0] q_vec[$];
    bit [7:0] q_clr[$];

    // Reference model state: phase 0 = waiting for a request, 1 = INT raised, 2 = granted.
    int       m_phase;
    bit       m_int;
    bit [7:0] m_isr;
    bit [7:0] m_vec;
    int       m_level;
    bit       m_spur;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_candidate(input bit [7:0] irr, input bit [7:0] mask, input bit [7:0] isr);
        int low;
        low = 8;
        for (int i = 7; i >= 0; i--) if (isr[i]) low = i;
        for (int i = 0; i < 8; i++) if (irr[i] && !mask[i] && i < low) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_int   = 1'b0;
        m_isr   = 8'd0;
        m_vec   = 8'd0;
        m_level = 0;
        m_spur  = 1'b0;
        q_vec.delete();
        q_clr.delete();
    endtask

    // One clock: drive strobes, advance the model on the pre-edge inputs, then compare.
    task automatic tick(input bit inta = 1'b0, input bit ns = 1'b0,
                        input bit sp = 1'b0, input bit [2:0] lvl = 3'd0);
        int       c;
        bit [7:0] clr;
        bit [7:0] aclr;
        bit [7:0] set;
        sif.inta_strobe     = inta;
        sif.eoi_nonspecific = ns;
        sif.eoi_specific    = sp;
        sif.eoi_level       = lvl;
        c    = ref_candidate(sif.interrupt_request, sif.interrupt_mask, m_isr);
        clr  = 8'd0;
        aclr = 8'd0;
        set  = 8'd0;
        if (sp) begin
            clr[lvl] = 1'b1;
        end else if (ns) begin
            for (int i = 0; i < 8; i++) begin
                if (m_isr[i]) begin
                    clr[i] = 1'b1;
                    break;
                end
            end
        end
        if (m_phase == 0) begin
            if (c >= 0) begin
                m_phase = 1;
                m_int   = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (inta) begin
                m_phase = 2;
                m_int   = 1'b0;
                if (c >= 0) begin
                    m_level = c;
                    m_spur  = 1'b0;
                    set[c]  = 1'b1;
                    q_clr.push_back(set);
                end else begin
                    m_level = 7;
                    m_spur  = 1'b1;
                end
            end
        end else begin
            if (inta) begin
                m_phase = 0;
                m_vec   = {sif.vector_base, 3'(m_level)};
                q_vec.push_back(m_vec);
                if (sif.auto_eoi && !m_spur) aclr[m_level] = 1'b1;
            end
        end
        m_isr = (m_isr & ~(clr | aclr)) | set;
        @(posedge clock);
        #1;
        sif.inta_strobe     = 1'b0;
        sif.eoi_nonspecific = 1'b0;
        sif.eoi_specific    = 1'b0;
        check8("int_out", {7'd0, sif.int_out}, {7'd0, m_int});
        check8("in_service", sif.in_service, m_isr);
        check8("vector_held", sif.vector, m_vec);
    endtask

    task automatic set_in(input bit [7:0] irr, input bit [7:0] mask, input bit [4:0] base, input bit auto_e);
        sif.interrupt_request = irr;
        sif.interrupt_mask    = mask;
        sif.vector_base       = base;
        sif.auto_eoi          = auto_e;
    endtask

    task automatic check_outputs_zero(input string tag);
        check8({tag, "_int"}, {7'd0, sif.int_out}, 8'd0);
        check8({tag, "_isr"}, sif.in_service, 8'd0);
        check8({tag, "_clr"}, sif.clear_irr, 8'd0);
        check8({tag, "_vec"}, sif.vector, 8'd0);
        check8({tag, "_vv"}, {7'd0, sif.vector_valid}, 8'd0);
    endtask

    // Reset is dropped between edges and the outputs are sampled before any edge arrives.
    task automatic reset_mid(input string tag);
        reset = 1'b0;
        #2;
        check_outputs_zero(tag);
        model_reset();
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: pops expected pulses whenever the DUT presents one.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                if (sif.vector_valid) begin
                    if (q_vec.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL vector_pulse: got unexpected %02h expected none", sif.vector);
                    end else begin
                        check8("vector_pulse", sif.vector, q_vec.pop_front());
                    end
                end
                if (sif.clear_irr != 8'd0) begin
                    if (q_clr.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL clear_irr_pulse: got unexpected %02h expected none", sif.clear_irr);
                    end else begin
                        check8("clear_irr_pulse", sif.clear_irr, q_clr.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        set_in(8'h00, 8'h00, 5'h08, 1'b0);
        sif.inta_strobe     = 1'b0;
        sif.eoi_nonspecific = 1'b0;
        sif.eoi_specific    = 1'b0;
        sif.eoi_level       = 3'd0;
        model_reset();
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check_outputs_zero("reset");
        reset = 1'b1;

        // Basic grant of IR0 with base 0x08.
        set_in(8'h01, 8'h00, 5'h08, 1'b0);
        check8("t1_int_before", {7'd0, sif.int_out}, 8'd0);
        tick();
        check8("t1_int_latency", {7'd0, sif.int_out}, 8'd1);
        tick(1'b1);
        check8("t1_isr", sif.in_service, 8'h01);
        check8("t1_clear_irr", sif.clear_irr, 8'h01);
        sif.interrupt_request = 8'h00;
        tick();
        tick(1'b1);
        check8("t1_vector", sif.vector, 8'h40);
        check8("t1_vector_valid", {7'd0, sif.vector_valid}, 8'd1);
        tick(1'b0, 1'b1);
        check8("t1_eoi", sif.in_service, 8'h00);

        // Priority among IR0..IR2, then non-specific EOI lets IR1 through.
        set_in(8'h07, 8'h00, 5'h08, 1'b0);
        tick();
        tick(1'b1);
        check8("t2_isr_ir0", sif.in_service, 8'h01);
        tick(1'b1);
        check8("t2_vector_ir0", sif.vector, 8'h40);
        sif.interrupt_request = 8'h06;
        tick(1'b0, 1'b1);
        check8("t2_isr_after_eoi", sif.in_service, 8'h00);
        tick();
        check8("t2_int_ir1", {7'd0, sif.int_out}, 8'd1);
        tick(1'b1);
        check8("t2_isr_ir1", sif.in_service, 8'h02);
        sif.interrupt_request = 8'h00;
        tick(1'b1);
        check8("t2_vector_ir1", sif.vector, 8'h41);
        tick(1'b0, 1'b1);

        // Nesting: IR4 blocked by IR2 in service, IR1 nests above it.
        set_in(8'h04, 8'h00, 5'h08, 1'b0);
        tick();
        tick(1'b1);
        sif.interrupt_request = 8'h00;
        tick(1'b1);
        check8("t3_isr_ir2", sif.in_service, 8'h04);
        sif.interrupt_request = 8'h10;
        tick();
        tick();
        check8("t3_no_int", {7'd0, sif.int_out}, 8'd0);
        sif.interrupt_request = 8'h02;
        tick();
        check8("t3_int_nest", {7'd0, sif.int_out}, 8'd1);
        tick(1'b1);
        check8("t3_isr_nest", sif.in_service, 8'h06);
        sif.interrupt_request = 8'h00;
        tick(1'b1);
        tick(1'b0, 1'b0, 1'b1, 3'd5);
        check8("t3_eoi_clear_bit", sif.in_service, 8'h06);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 3'd2);
        check8("t3_isr_empty", sif.in_service, 8'h00);

        // Masking, then a request withdrawn before INTA1 yields the spurious IR7 vector.
        set_in(8'h01, 8'h01, 5'h08, 1'b0);
        tick();
        tick();
        check8("t4_masked", {7'd0, sif.int_out}, 8'd0);
        sif.interrupt_mask = 8'h00;
        tick();
        sif.interrupt_request = 8'h00;
        tick();
        check8("t4_int_held", {7'd0, sif.int_out}, 8'd1);
        tick(1'b1);
        check8("t4_spurious_isr", sif.in_service, 8'h00);
        check8("t4_spurious_clr", sif.clear_irr, 8'h00);
        tick(1'b1);
        check8("t4_spurious_vec", sif.vector, 8'h47);

        // Auto-EOI on IR3.
        set_in(8'h08, 8'h00, 5'h08, 1'b1);
        tick();
        tick(1'b1);
        check8("t5_isr_inta1", sif.in_service, 8'h08);
        sif.interrupt_request = 8'h00;
        tick(1'b1);
        check8("t5_isr_inta2", sif.in_service, 8'h00);
        check8("t5_vec_level", {5'd0, sif.vector[2:0]}, 8'd3);
        sif.auto_eoi = 1'b0;

        // EOI coinciding with a grant, then both EOI strobes together.
        set_in(8'h02, 8'h00, 5'h08, 1'b0);
        tick();
        tick(1'b1);
        sif.interrupt_request = 8'h00;
        tick(1'b1);
        sif.interrupt_request = 8'h01;
        tick();
        tick(1'b1, 1'b1);
        check8("t6_eoi_and_set", sif.in_service, 8'h01);
        sif.interrupt_request = 8'h00;
        tick(1'b1);
        tick(1'b0, 1'b1, 1'b1, 3'd3);
        check8("t6_both_eoi", sif.in_service, 8'h01);
        tick(1'b0, 1'b0, 1'b1, 3'd0);

        // Reset while waiting for the second INTA.
        set_in(8'h04, 8'h00, 5'h08, 1'b0);
        tick();
        tick(1'b1);
        check8("t7_isr_before_reset", sif.in_service, 8'h04);
        reset_mid("t7_reset");
        tick();
        check8("t7_int_after_reset", {7'd0, sif.int_out}, 8'd1);
        tick(1'b1);
        sif.interrupt_request = 8'h00;
        tick(1'b1);
        tick(1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            int r;
            if ($urandom_range(3) == 0) sif.interrupt_request = 8'($urandom);
            if ($urandom_range(15) == 0) sif.interrupt_mask = 8'($urandom) & 8'($urandom);
            if ($urandom_range(31) == 0) sif.vector_base = 5'($urandom);
            if ($urandom_range(31) == 0) sif.auto_eoi = 1'($urandom);
            if (n == 700) reset_mid("rand_reset");
            r = $urandom_range(9);
            tick($urandom_range(2) == 0, r == 0 || r == 2, r == 1 || r == 2, 3'($urandom));
        end

        sif.interrupt_request = 8'h00;
        repeat (2) tick();
        check8("vec_queue_empty", 8'(q_vec.size()), 8'd0);
        check8("clr_queue_empty", 8'(q_clr.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
